// File: rtl/a2d_pkg.sv
// a2d_pkg: shared types and helpers for the A2D scan interface.
// Holds engine/control state encodings and the ADC command builder.
package a2d_pkg;

    localparam int CMD_W  = 16;
    localparam int CH_POS = 11;

    typedef enum logic [2:0] {
        XF_IDLE,
        XF_FRONT,
        XF_SHIFT,
        XF_BACK,
        XF_GAP
    } xf_state_t;

    typedef enum logic [2:0] {
        C_IDLE,
        C_SGL_A,
        C_SGL_B,
        C_SCAN,
        C_DRAIN
    } ctl_state_t;

    function automatic logic [CMD_W-1:0] build_cmd(input logic [2:0] ch);
        logic [CMD_W-1:0] c;
        c = '0;
        c[CH_POS +: 3] = ch;
        return c;
    endfunction

endpackage

// File: rtl/a2d_spi_xfer.sv
// a2d_spi_xfer: one 16-bit SPI transaction per start pulse.
// SCLK idles high; MOSI moves on SCLK fall, MISO sampled on rise.
module a2d_spi_xfer
    import a2d_pkg::*;
#(
    parameter int SCLK_DIV = 32,
    parameter int FRAME_W  = CMD_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [CMD_W-1:0]   cmd,
    output logic               idle,
    output logic               done,
    output logic [FRAME_W-1:0] frame,
    output logic               SS_n,
    output logic               SCLK,
    output logic               MOSI,
    input  logic               MISO
);

    localparam int CNT_W = $clog2(SCLK_DIV);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(SCLK_DIV / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(SCLK_DIV - 1);

    xf_state_t          state_q;
    xf_state_t          state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [3:0]         bit_q;
    logic [CMD_W-1:0]   tx_q;
    logic [FRAME_W-1:0] rx_q;
    logic               cnt_clr;
    logic               fall;
    logic               rise;
    logic               fin;

    assign idle = (state_q == XF_IDLE);

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= XF_IDLE;
        else     state_q <= state_d;
    end

    // Next state and SCLK edge strobes from the half-period counter
    always_comb begin
        state_d = state_q;
        cnt_clr = 1'b0;
        fall    = 1'b0;
        rise    = 1'b0;
        fin     = 1'b0;
        unique case (state_q)
            XF_IDLE: begin
                if (start) begin
                    state_d = XF_FRONT;
                    cnt_clr = 1'b1;
                end
            end
            XF_FRONT: begin
                if (cnt_q == HALF_M1) begin
                    state_d = XF_SHIFT;
                    fall    = 1'b1;
                    cnt_clr = 1'b1;
                end
            end
            XF_SHIFT: begin
                if (cnt_q == HALF_M1) begin
                    rise = 1'b1;
                    if (bit_q == 4'd15) begin
                        state_d = XF_BACK;
                        cnt_clr = 1'b1;
                    end
                end else if (cnt_q == FULL_M1) begin
                    fall    = 1'b1;
                    cnt_clr = 1'b1;
                end
            end
            XF_BACK: begin
                if (cnt_q == HALF_M1) begin
                    state_d = XF_GAP;
                    fin     = 1'b1;
                    cnt_clr = 1'b1;
                end
            end
            XF_GAP: begin
                if (cnt_q == HALF_M1) begin
                    state_d = XF_IDLE;
                    cnt_clr = 1'b1;
                end
            end
            default: state_d = XF_IDLE;
        endcase
    end

    // Counters, shift registers and SPI pins
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            bit_q <= '0;
            tx_q  <= '0;
            rx_q  <= '0;
            frame <= '0;
            done  <= 1'b0;
            SS_n  <= 1'b1;
            SCLK  <= 1'b1;
            MOSI  <= 1'b0;
        end else begin
            done <= fin;
            if (cnt_clr)
                cnt_q <= '0;
            else if (state_q != XF_IDLE)
                cnt_q <= cnt_q + CNT_W'(1);
            if (start && state_q == XF_IDLE) begin
                tx_q  <= cmd;
                bit_q <= '0;
                SS_n  <= 1'b0;
            end
            if (fall) begin
                SCLK <= 1'b0;
                MOSI <= tx_q[CMD_W-1];
                tx_q <= {tx_q[CMD_W-2:0], 1'b0};
            end
            if (rise) begin
                SCLK  <= 1'b1;
                rx_q  <= FRAME_W'({rx_q, MISO});
                bit_q <= bit_q + 4'd1;
            end
            if (fin) begin
                SS_n  <= 1'b1;
                MOSI  <= 1'b0;
                frame <= rx_q;
            end
        end
    end

endmodule

// File: rtl/a2d_scan_intf.sv
// a2d_scan_intf: single-shot and round-robin scan control for an SPI ADC.
// Frames return the channel commanded one transaction earlier.
module a2d_scan_intf
    import a2d_pkg::*;
#(
    parameter int NUM_CH   = 8,
    parameter int RES_W    = 12,
    parameter int SCLK_DIV = 32,
    parameter int CH_W     = $clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              strt_cnv,
    input  logic [CH_W-1:0]   chnnl,
    input  logic              scan_en,
    input  logic [NUM_CH-1:0] scan_mask,
    input  logic [CH_W-1:0]   rd_ch,
    output logic [RES_W-1:0]  rd_res,
    output logic [RES_W-1:0]  res,
    output logic [CH_W-1:0]   res_ch,
    output logic              res_vld,
    output logic              cnv_cmplt,
    output logic              busy,
    output logic              SS_n,
    output logic              SCLK,
    output logic              MOSI,
    input  logic              MISO
);

    ctl_state_t       ctl_q;
    ctl_state_t       ctl_d;
    logic [CH_W-1:0]  cur_ch;
    logic [CH_W-1:0]  prev_ch;
    logic [CH_W-1:0]  nxt_q;
    logic [CH_W-1:0]  launch_ch;
    logic [CH_W-1:0]  after_ch;
    logic [CH_W-1:0]  first_ch;
    logic             have_prev;
    logic             go_q;
    logic             launch;
    logic             accept;
    logic             deliver;
    logic             xf_idle;
    logic             xf_done;
    logic [RES_W-1:0] xf_frame;
    logic [RES_W-1:0] bank [NUM_CH];

    // First set mask bit at or after 'from', wrapping
    function automatic logic [CH_W-1:0] pick_ch(
        input logic [NUM_CH-1:0] mask,
        input logic [CH_W-1:0]   from
    );
        logic [CH_W-1:0] sel;
        int              idx;
        sel = from;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            idx = int'(from) + i;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            if (mask[idx[CH_W-1:0]]) sel = idx[CH_W-1:0];
        end
        return sel;
    endfunction

    assign after_ch = (cur_ch == CH_W'(NUM_CH - 1)) ? '0 : cur_ch + CH_W'(1);
    assign first_ch = pick_ch(scan_mask, '0);
    assign busy     = (ctl_q != C_IDLE);
    assign rd_res   = bank[rd_ch];
    assign deliver  = xf_done && have_prev && (ctl_q != C_IDLE);

    a2d_spi_xfer #(
        .SCLK_DIV (SCLK_DIV),
        .FRAME_W  (RES_W)
    ) u_xfer (
        .clk   (clk),
        .rst   (rst),
        .start (launch),
        .cmd   (build_cmd(3'(launch_ch))),
        .idle  (xf_idle),
        .done  (xf_done),
        .frame (xf_frame),
        .SS_n  (SS_n),
        .SCLK  (SCLK),
        .MOSI  (MOSI),
        .MISO  (MISO)
    );

    // Mode state register
    always_ff @(posedge clk) begin
        if (rst) ctl_q <= C_IDLE;
        else     ctl_q <= ctl_d;
    end

    // Mode sequencing: launches happen only while the engine is idle
    always_comb begin
        ctl_d     = ctl_q;
        launch    = 1'b0;
        launch_ch = cur_ch;
        accept    = 1'b0;
        unique case (ctl_q)
            C_IDLE: begin
                if (scan_en) begin
                    if (|scan_mask) begin
                        launch    = 1'b1;
                        launch_ch = first_ch;
                        ctl_d     = C_SCAN;
                    end
                end else if (strt_cnv) begin
                    launch    = 1'b1;
                    launch_ch = chnnl;
                    accept    = 1'b1;
                    ctl_d     = C_SGL_A;
                end
            end
            C_SGL_A: begin
                if (xf_idle) begin
                    launch = 1'b1;
                    ctl_d  = C_SGL_B;
                end
            end
            C_SGL_B, C_DRAIN: begin
                if (xf_idle) ctl_d = C_IDLE;
            end
            C_SCAN: begin
                if (xf_idle) begin
                    launch = 1'b1;
                    if (go_q) launch_ch = nxt_q;
                    else      ctl_d     = C_DRAIN;
                end
            end
            default: ctl_d = C_IDLE;
        endcase
    end

    // Channel tracking, scan decision and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_ch    <= '0;
            prev_ch   <= '0;
            nxt_q     <= '0;
            have_prev <= 1'b0;
            go_q      <= 1'b0;
            res       <= '0;
            res_ch    <= '0;
            res_vld   <= 1'b0;
            cnv_cmplt <= 1'b0;
        end else begin
            res_vld <= deliver;
            if (launch) begin
                prev_ch   <= cur_ch;
                cur_ch    <= launch_ch;
                have_prev <= (ctl_q != C_IDLE);
            end
            if (xf_done && ctl_q == C_SCAN) begin
                go_q  <= scan_en && (|scan_mask);
                nxt_q <= pick_ch(scan_mask, after_ch);
            end
            if (accept) cnv_cmplt <= 1'b0;
            if (deliver) begin
                res    <= xf_frame;
                res_ch <= prev_ch;
                if (ctl_q == C_SGL_B) cnv_cmplt <= 1'b1;
            end
        end
    end

    // Per-channel result bank
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) bank[i] <= '0;
        end else if (deliver) begin
            bank[prev_ch] <= xf_frame;
        end
    end

endmodule

// File: tb/tb_a2d_scan_intf.sv
// tb_a2d_scan_intf: scoreboard bench with an SPI ADC model per instance.
// Instance 0 uses defaults; instance 1 uses NUM_CH=4, RES_W=10, SCLK_DIV=8.
module tb_a2d_scan_intf;

    logic clk;
    logic rst;

    logic       strt0, scan_en0, vld0, cmplt0, busy0;
    logic [2:0] chnnl0, rd_ch0, res_ch0;
    logic [7:0] mask0;
    logic [11:0] rd_res0, res0;

    logic       strt1, scan_en1, vld1, cmplt1, busy1;
    logic [1:0] chnnl1, rd_ch1, res_ch1;
    logic [3:0] mask1;
    logic [9:0] rd_res1, res1;

    logic [1:0] ss, sck, mo, mi;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q [$];
    logic [31:0] cmd_q [$];
    logic [15:0] adc_val [8];

    int          win [2];
    int          low [2];
    logic [15:0] osr [2];
    logic [15:0] rcmd [2];
    logic [2:0]  pend [2];
    logic [1:0]  skip;
    logic [1:0]  ss_q, sck_q;
    int          base;

    a2d_scan_intf u_dut0 (
        .clk(clk), .rst(rst), .strt_cnv(strt0), .chnnl(chnnl0),
        .scan_en(scan_en0), .scan_mask(mask0), .rd_ch(rd_ch0),
        .rd_res(rd_res0), .res(res0), .res_ch(res_ch0), .res_vld(vld0),
        .cnv_cmplt(cmplt0), .busy(busy0), .SS_n(ss[0]), .SCLK(sck[0]),
        .MOSI(mo[0]), .MISO(mi[0])
    );

    a2d_scan_intf #(.NUM_CH(4), .RES_W(10), .SCLK_DIV(8)) u_dut1 (
        .clk(clk), .rst(rst), .strt_cnv(strt1), .chnnl(chnnl1),
        .scan_en(scan_en1), .scan_mask(mask1), .rd_ch(rd_ch1),
        .rd_res(rd_res1), .res(res1), .res_ch(res_ch1), .res_vld(vld1),
        .cnv_cmplt(cmplt1), .busy(busy1), .SS_n(ss[1]), .SCLK(sck[1]),
        .MOSI(mo[1]), .MISO(mi[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic push_cmd(input int inst, input int ch);
        logic [15:0] c;
        c = 16'(ch) << 11;
        cmd_q.push_back({16'(inst), c});
    endtask

    task automatic push_res(input int inst, input int ch);
        logic [15:0] v;
        v = adc_val[ch] & ((inst != 0) ? 16'h03FF : 16'h0FFF);
        exp_q.push_back({8'(inst), 8'(ch), v});
    endtask

    // ADC model: shifts frames out on SCLK fall, captures commands on rise
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (ss[i] === 1'b0 && ss_q[i] === 1'b1) begin
                low[i] = 0;
                osr[i] = adc_val[pend[i]];
                rcmd[i] = '0;
            end
            if (ss[i] === 1'b0) low[i]++;
            if (ss[i] === 1'b0 && sck[i] === 1'b0 && sck_q[i] === 1'b1) begin
                mi[i] = osr[i][15];
                osr[i] = {osr[i][14:0], 1'b0};
            end
            if (ss[i] === 1'b0 && sck[i] === 1'b1 && sck_q[i] === 1'b0)
                rcmd[i] = {rcmd[i][14:0], mo[i]};
            if (ss[i] === 1'b1 && ss_q[i] === 1'b0) begin
                logic [31:0] e;
                win[i]++;
                if (skip[i]) begin
                    skip[i] = 1'b0;
                end else begin
                    e = (cmd_q.size() != 0) ? cmd_q.pop_front() : 32'hDEAD_DEAD;
                    chk("cmd", {16'(i), rcmd[i]}, e);
                    chk("ss_low", low[i], (i != 0) ? 132 : 528);
                end
                pend[i] = rcmd[i][13:11];
            end
            ss_q[i] = ss[i];
            sck_q[i] = sck[i];
        end
    end

    // Result monitor: every res_vld pops one expected entry
    always @(negedge clk) begin
        logic [31:0] e;
        if (vld0 === 1'b1) begin
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_DEAD;
            chk("res0", {8'd0, 8'(res_ch0), 16'(res0)}, e);
        end
        if (vld1 === 1'b1) begin
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_DEAD;
            chk("res1", {8'd1, 8'(res_ch1), 16'(res1)}, e);
        end
    end

    initial begin
        rst = 1'b1;
        strt0 = 0; scan_en0 = 0; chnnl0 = 0; mask0 = 0; rd_ch0 = 0;
        strt1 = 0; scan_en1 = 0; chnnl1 = 0; mask1 = 0; rd_ch1 = 0;
        mi = 2'b00; skip = 2'b00; ss_q = 2'b11; sck_q = 2'b11;
        for (int i = 0; i < 2; i++) begin
            win[i] = 0; low[i] = 0; osr[i] = 0; rcmd[i] = 0; pend[i] = 0;
        end
        for (int c = 0; c < 8; c++)
            adc_val[c] = 16'h7000 | (16'(c) * 16'h0135 + 16'h0208);
        adc_val[3] = 16'hFA5C;

        repeat (3) @(negedge clk);
        chk("rst_ss", ss[0], 1);
        chk("rst_sclk", sck[0], 1);
        chk("rst_mosi", mo[0], 0);
        chk("rst_busy", busy0, 0);
        chk("rst_cmplt", cmplt0, 0);
        chk("rst_vld", vld0, 0);
        chk("rst_res", res0, 0);
        chk("rst_resch", res_ch0, 0);
        chk("rst_bank", rd_res0, 0);
        rst = 1'b0;
        @(negedge clk);

        // single conversion of channel 3
        push_cmd(0, 3); push_cmd(0, 3); push_res(0, 3);
        chnnl0 = 3; strt0 = 1;
        @(negedge clk);
        strt0 = 0;
        chk("t1_busy", busy0, 1);
        for (int n = 0; n < 3000 && !cmplt0; n++) @(negedge clk);
        chk("t1_cmplt", cmplt0, 1);
        chk("t1_res", res0, 12'hA5C);
        chk("t1_resch", res_ch0, 3);
        for (int n = 0; n < 200 && busy0; n++) @(negedge clk);
        chk("t1_idle", busy0, 0);
        rd_ch0 = 3; #1;
        chk("t1_bank3", rd_res0, 12'hA5C);
        chk("t1_win", win[0], 2);
        chk("t1_cmdq", cmd_q.size(), 0);

        // scan over channels 0,2,7 then stop mid-frame
        base = win[0];
        push_cmd(0, 0); push_cmd(0, 2); push_cmd(0, 7);
        push_cmd(0, 0); push_cmd(0, 2); push_cmd(0, 2);
        push_res(0, 0); push_res(0, 2); push_res(0, 7);
        push_res(0, 0); push_res(0, 2);
        mask0 = 8'b1000_0101; scan_en0 = 1;
        for (int n = 0; n < 5000 && win[0] < base + 4; n++) @(negedge clk);
        chk("t2_win4", win[0], base + 4);
        for (int n = 0; n < 200 && ss[0]; n++) @(negedge clk);
        chk("t2_sslo", ss[0], 0);
        repeat (100) @(negedge clk);
        scan_en0 = 0;
        for (int n = 0; n < 3000 && busy0; n++) @(negedge clk);
        chk("t2_idle", busy0, 0);
        chk("t2_win", win[0], base + 6);
        chk("t2_expq", exp_q.size(), 0);
        for (int k = 0; k < 3; k++) begin
            int c;
            c = (k == 0) ? 0 : ((k == 1) ? 2 : 7);
            rd_ch0 = 3'(c); #1;
            chk("t2_bank", rd_res0, adc_val[c] & 16'h0FFF);
        end
        rd_ch0 = 1; #1;
        chk("t2_bank1", rd_res0, 0);
        rd_ch0 = 2; #1;
        chk("t2_rd2", rd_res0, adc_val[2] & 16'h0FFF);
        chk("t2_cmplt", cmplt0, 1);

        // mask bit 2 cleared mid-frame, then scan stopped
        base = win[0];
        push_cmd(0, 0); push_cmd(0, 7); push_cmd(0, 7);
        push_res(0, 0); push_res(0, 7);
        mask0 = 8'b1000_0101; scan_en0 = 1;
        for (int n = 0; n < 200 && ss[0]; n++) @(negedge clk);
        repeat (100) @(negedge clk);
        mask0 = 8'b1000_0001;
        for (int n = 0; n < 2000 && win[0] < base + 1; n++) @(negedge clk);
        for (int n = 0; n < 200 && ss[0]; n++) @(negedge clk);
        repeat (100) @(negedge clk);
        scan_en0 = 0;
        for (int n = 0; n < 3000 && busy0; n++) @(negedge clk);
        chk("t3_idle", busy0, 0);
        chk("t3_win", win[0], base + 3);
        chk("t3_expq", exp_q.size(), 0);

        // strt_cnv alongside scan_en and while busy are both dropped
        base = win[0];
        push_cmd(0, 1); push_cmd(0, 1); push_res(0, 1);
        mask0 = 8'b0000_0010; chnnl0 = 5; scan_en0 = 1; strt0 = 1;
        @(negedge clk);
        strt0 = 0;
        for (int n = 0; n < 200 && ss[0]; n++) @(negedge clk);
        repeat (50) @(negedge clk);
        chnnl0 = 4; strt0 = 1;
        @(negedge clk);
        strt0 = 0;
        repeat (50) @(negedge clk);
        scan_en0 = 0;
        for (int n = 0; n < 3000 && busy0; n++) @(negedge clk);
        repeat (200) @(negedge clk);
        chk("t4_idle", busy0, 0);
        chk("t4_cmplt", cmplt0, 1);
        chk("t4_win", win[0], base + 2);
        chk("t4_cmdq", cmd_q.size(), 0);

        // reset in the middle of SHIFT
        base = win[0];
        skip[0] = 1'b1;
        chnnl0 = 5; strt0 = 1;
        @(negedge clk);
        strt0 = 0;
        chk("t5_cmplt_clr", cmplt0, 0);
        for (int n = 0; n < 200 && sck[0]; n++) @(negedge clk);
        repeat (40) @(negedge clk);
        chk("t5_shift", ss[0], 0);
        rst = 1'b1;
        @(negedge clk);
        chk("t5_ss", ss[0], 1);
        chk("t5_sclk", sck[0], 1);
        chk("t5_busy", busy0, 0);
        chk("t5_res", res0, 0);
        rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            rd_ch0 = 3'(c); #1;
            chk("t5_bank", rd_res0, 0);
        end
        repeat (1200) @(negedge clk);
        chk("t5_quiet", busy0, 0);
        chk("t5_win", win[0], base + 1);

        // reduced-parameter instance, channel 3
        base = win[1];
        push_cmd(1, 3); push_cmd(1, 3); push_res(1, 3);
        chnnl1 = 3; strt1 = 1;
        @(negedge clk);
        strt1 = 0;
        for (int n = 0; n < 1000 && !cmplt1; n++) @(negedge clk);
        chk("t6_cmplt", cmplt1, 1);
        chk("t6_res", res1, 10'h25C);
        chk("t6_resch", res_ch1, 3);
        for (int n = 0; n < 100 && busy1; n++) @(negedge clk);
        chk("t6_idle", busy1, 0);
        rd_ch1 = 3; #1;
        chk("t6_bank3", rd_res1, 10'h25C);
        chk("t6_win", win[1], base + 2);

        repeat (20) @(negedge clk);
        chk("end_expq", exp_q.size(), 0);
        chk("end_cmdq", cmd_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
